// File: rtl/qsys_ram_pkg.sv
// rtl/qsys_ram_pkg.sv - shared types and helpers for the qsys_ram_dp dual-slave RAM
package qsys_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    localparam int MAX_BYTES = 64;

    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    // Lanes s2 may commit; s1 owns every lane both ports enable on a same-address collision.
    function automatic logic [MAX_BYTES-1:0] s2_lane_mask(
        input logic [MAX_BYTES-1:0] be1,
        input logic [MAX_BYTES-1:0] be2,
        input logic                 collide
    );
        return collide ? (be2 & ~be1) : be2;
    endfunction

endpackage

// File: rtl/qsys_ram_rd_pipe.sv
// rtl/qsys_ram_rd_pipe.sv - per-port read latency pipeline that freezes while the clock enable is low
module qsys_ram_rd_pipe #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             issue,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    if (READ_LATENCY == 1) begin : g_lat1
        logic valid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= issue & en;
            end
        end

        assign out_data  = rd_data;
        assign out_valid = valid_q;
    end else begin : g_lat2
        logic             stage_valid;
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        // The inner stage holds while disabled; the output beat is shown once, never repeated.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_valid <= 1'b0;
                valid_q     <= 1'b0;
                data_q      <= '0;
            end else if (en) begin
                stage_valid <= issue;
                valid_q     <= stage_valid;
                if (stage_valid) begin
                    data_q <= rd_data;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end

        assign out_data  = data_q;
        assign out_valid = valid_q;
    end

endmodule

// File: rtl/qsys_ram_dp.sv
// rtl/qsys_ram_dp.sv - dual-slave Avalon-MM on-chip RAM with clear engine; QSYS_RAM_PARITY_EN adds per-byte parity
module qsys_ram_dp
    import qsys_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 13,
    parameter int                    DEPTH          = 5120,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
`ifdef QSYS_RAM_PARITY_EN
    output logic                    s1_parity_err,
    output logic                    s2_parity_err,
`endif
    output logic                    init_done
);

    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IW-1:0]       LAST    = IW'(DEPTH - 1);
`ifdef QSYS_RAM_PARITY_EN
    localparam int PBITS = BYTES;
    localparam int PW    = DATA_WIDTH + 1;
`else
    localparam int PBITS = 0;
    localparam int PW    = DATA_WIDTH;
`endif
    localparam int MW = DATA_WIDTH + PBITS;

    logic [MW-1:0] mem [DEPTH];

    clr_state_t    state;
    logic [IW-1:0] cnt;
    logic          en;
    logic          clr_we;
    logic          s1_inr, s2_inr;
    logic          s1_acc, s2_acc;
    logic          s1_we, s2_we;
    logic          s1_re, s2_re;
    logic [IW-1:0] a1, a2;
    logic [BYTES-1:0] s2_be_eff;
    logic [MW-1:0] q1, q2;
    logic [PW-1:0] p1_in, p2_in, p1_out, p2_out;

    function automatic logic [MW-1:0] clear_word();
        logic [MW-1:0] w;
        w = MW'(CLEAR_VALUE);
`ifdef QSYS_RAM_PARITY_EN
        for (int b = 0; b < BYTES; b++) begin
            w[DATA_WIDTH+b] = ^CLEAR_VALUE[b*8 +: 8];
        end
`endif
        return w;
    endfunction

`ifdef QSYS_RAM_PARITY_EN
    function automatic logic par_err(input logic [MW-1:0] w);
        logic e;
        e = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            e = e | ((^w[b*8 +: 8]) != w[DATA_WIDTH+b]);
        end
        return e;
    endfunction
`endif

    assign en     = clken & ~reset_req;
    assign clr_we = en & (state == CLEAR);

    assign s1_waitrequest = ~init_done | ~clken | reset_req;
    assign s2_waitrequest = ~init_done | ~clken | reset_req;

    assign s1_inr = {1'b0, s1_address} < DEPTH_W;
    assign s2_inr = {1'b0, s2_address} < DEPTH_W;
    assign a1     = s1_address[IW-1:0];
    assign a2     = s2_address[IW-1:0];

    assign s1_acc = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
    assign s2_acc = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
    assign s1_we  = s1_acc & s1_write & s1_inr;
    assign s2_we  = s2_acc & s2_write & s2_inr;
    assign s1_re  = s1_acc & s1_read & ~s1_write;
    assign s2_re  = s2_acc & s2_read & ~s2_write;

    assign s2_be_eff = BYTES'(s2_lane_mask(MAX_BYTES'(s1_byteenable), MAX_BYTES'(s2_byteenable),
                                           s1_we && (s1_address == s2_address)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt       <= '0;
            init_done <= (CLEAR_ON_RESET == 0);
        end else if (clr_we) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state     <= READY;
                init_done <= 1'b1;
            end
        end
    end

    // s2 lanes are committed first so a colliding s1 lane always lands last.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= clear_word();
        end
        for (int b = 0; b < BYTES; b++) begin
            if (s2_we && s2_be_eff[b]) begin
                mem[a2][b*8 +: 8] <= s2_writedata[b*8 +: 8];
`ifdef QSYS_RAM_PARITY_EN
                mem[a2][DATA_WIDTH+b] <= ^s2_writedata[b*8 +: 8];
`endif
            end
            if (s1_we && s1_byteenable[b]) begin
                mem[a1][b*8 +: 8] <= s1_writedata[b*8 +: 8];
`ifdef QSYS_RAM_PARITY_EN
                mem[a1][DATA_WIDTH+b] <= ^s1_writedata[b*8 +: 8];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            if (s1_re) begin
                q1 <= s1_inr ? mem[a1] : '0;
            end
            if (s2_re) begin
                q2 <= s2_inr ? mem[a2] : '0;
            end
        end
    end

`ifdef QSYS_RAM_PARITY_EN
    assign p1_in = {par_err(q1), q1[DATA_WIDTH-1:0]};
    assign p2_in = {par_err(q2), q2[DATA_WIDTH-1:0]};
    assign s1_parity_err = s1_readdatavalid & p1_out[DATA_WIDTH];
    assign s2_parity_err = s2_readdatavalid & p2_out[DATA_WIDTH];
`else
    assign p1_in = q1;
    assign p2_in = q2;
`endif

    qsys_ram_rd_pipe #(.WIDTH(PW), .READ_LATENCY(READ_LATENCY)) u_pipe_s1 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .issue     (s1_re),
        .rd_data   (p1_in),
        .out_data  (p1_out),
        .out_valid (s1_readdatavalid)
    );

    qsys_ram_rd_pipe #(.WIDTH(PW), .READ_LATENCY(READ_LATENCY)) u_pipe_s2 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .issue     (s2_re),
        .rd_data   (p2_in),
        .out_data  (p2_out),
        .out_valid (s2_readdatavalid)
    );

    assign s1_readdata = p1_out[DATA_WIDTH-1:0];
    assign s2_readdata = p2_out[DATA_WIDTH-1:0];

endmodule
